byte_serializer: RTL and testbench

Parallel-to-serial front end for the 8:1 bit-select multiplexer stage. It accepts a WIDTH-bit word over a valid/ready handshake and holds it in a word register. It steps a bit-index counter that drives the multiplexer select, and emits one bit per accepted downstream handshake with first/last framing. A one-word prefetch buffer lets back-to-back words stream with no idle cycle between them.

---
 rtl/byte_serializer.sv | 111 +++++++++++
 tb/tb_byte_serializer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word, walks a bit select over it
// and emits one framed bit per downstream handshake, with a one-word prefetch buffer.
module byte_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         word,
    output logic [$clog2(WIDTH)-1:0] sel,
    output logic                     bit_out,
    output logic                     bit_valid,
    input  logic                     bit_ready,
    output logic                     bit_first,
    output logic                     bit_last,
    output logic                     busy
);

    localparam int unsigned SEL_W = $clog2(WIDTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state, state_n;
    logic [SEL_W-1:0] idx, idx_n;
    logic [WIDTH-1:0] word_n;
    logic [WIDTH-1:0] pend, pend_n;
    logic             pend_full, pend_full_n;

    logic accept;
    logic hshake;
    logic last_hs;
    logic at_last;

    assign in_ready  = rst_n & ~pend_full;
    assign bit_valid = (state == SHIFT);
    assign at_last   = (idx == SEL_W'(WIDTH - 1));
    assign sel       = MSB_FIRST ? (SEL_W'(WIDTH - 1) - idx) : idx;
    assign bit_out   = word[sel];
    assign bit_first = bit_valid & (idx == SEL_W'(0));
    assign bit_last  = bit_valid & at_last;
    assign busy      = (state == SHIFT) | pend_full;

    assign accept  = in_valid & in_ready;
    assign hshake  = bit_valid & bit_ready;
    assign last_hs = hshake & at_last;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            word      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            word      <= word_n;
            pend      <= pend_n;
            pend_full <= pend_full_n;
        end
    end

    // Next-state: reload order is prefetch buffer, then a word arriving on the last bit
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        word_n      = word;
        pend_n      = pend;
        pend_full_n = pend_full;

        case (state)
            IDLE: begin
                if (accept) begin
                    word_n  = in_data;
                    idx_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last_hs) begin
                    idx_n = '0;
                    if (pend_full) begin
                        word_n      = pend;
                        pend_full_n = 1'b0;
                    end else if (accept) begin
                        word_n = in_data;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    if (hshake) begin
                        idx_n = idx + SEL_W'(1);
                    end
                    if (accept) begin
                        pend_n      = in_data;
                        pend_full_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed self-checking bench for byte_serializer; runs an LSB-first and an
// MSB-first instance side by side from the same stimulus.
module tb_byte_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       bit_ready;

    logic       l_in_ready, l_bit_out, l_bit_valid, l_bit_first, l_bit_last, l_busy;
    logic [7:0] l_word;
    logic [2:0] l_sel;
    logic       m_in_ready, m_bit_out, m_bit_valid, m_bit_first, m_bit_last, m_busy;
    logic [7:0] m_word;
    logic [2:0] m_sel;

    int checks = 0;
    int errors = 0;

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_in_ready), .word(l_word), .sel(l_sel), .bit_out(l_bit_out),
        .bit_valid(l_bit_valid), .bit_ready(bit_ready), .bit_first(l_bit_first),
        .bit_last(l_bit_last), .busy(l_busy)
    );

    byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_in_ready), .word(m_word), .sel(m_sel), .bit_out(m_bit_out),
        .bit_valid(m_bit_valid), .bit_ready(bit_ready), .bit_first(m_bit_first),
        .bit_last(m_bit_last), .busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; bit_ready = 1'b1;
        step(); step(); #1;
        checks++; if (l_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", l_in_ready); end
        checks++; if (l_bit_valid !== 1'b0) begin errors++; $display("FAIL rst_bit_valid got %b exp 0", l_bit_valid); end
        checks++; if (l_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", l_busy); end
        checks++; if ({l_bit_first, l_bit_last} !== 2'b00) begin errors++; $display("FAIL rst_framing got %b exp 00", {l_bit_first, l_bit_last}); end
        checks++; if (l_word !== 8'h00) begin errors++; $display("FAIL rst_word got %h exp 00", l_word); end
        checks++; if (l_sel !== 3'd0) begin errors++; $display("FAIL rst_sel_lsb got %0d exp 0", l_sel); end
        checks++; if (m_sel !== 3'd7) begin errors++; $display("FAIL rst_sel_msb got %0d exp 7", m_sel); end
        step(); rst_n = 1'b1; #1;
        checks++; if (l_in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", l_in_ready); end
        checks++; if (l_bit_valid !== 1'b0) begin errors++; $display("FAIL rel_bit_valid got %b exp 0", l_bit_valid); end
    endtask

    // Send one word with bit_ready=1 and check both bit orders and framing
    task automatic run_word(input logic [7:0] w, input string tag);
        step(); in_valid = 1'b1; in_data = w; #1;
        checks++; if (l_in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b exp 1", tag, l_in_ready); end
        for (int i = 0; i < 8; i++) begin
            step(); in_valid = 1'b0; #1;
            checks++; if (l_bit_valid !== 1'b1) begin errors++; $display("FAIL %s_valid[%0d] got %b exp 1", tag, i, l_bit_valid); end
            checks++; if (l_sel !== 3'(i)) begin errors++; $display("FAIL %s_sel_lsb[%0d] got %0d exp %0d", tag, i, l_sel, i); end
            checks++; if (l_bit_out !== w[i]) begin errors++; $display("FAIL %s_bit_lsb[%0d] got %b exp %b", tag, i, l_bit_out, w[i]); end
            checks++; if (m_sel !== 3'(7 - i)) begin errors++; $display("FAIL %s_sel_msb[%0d] got %0d exp %0d", tag, i, m_sel, 7 - i); end
            checks++; if (m_bit_out !== w[7-i]) begin errors++; $display("FAIL %s_bit_msb[%0d] got %b exp %b", tag, i, m_bit_out, w[7-i]); end
            checks++; if (l_bit_first !== (i == 0)) begin errors++; $display("FAIL %s_first[%0d] got %b exp %b", tag, i, l_bit_first, (i == 0)); end
            checks++; if (l_bit_last !== (i == 7)) begin errors++; $display("FAIL %s_last[%0d] got %b exp %b", tag, i, l_bit_last, (i == 7)); end
        end
        step(); #1;
        checks++; if (l_bit_valid !== 1'b0) begin errors++; $display("FAIL %s_end_valid got %b exp 0", tag, l_bit_valid); end
        checks++; if (l_busy !== 1'b0) begin errors++; $display("FAIL %s_end_busy got %b exp 0", tag, l_busy); end
    endtask

    task automatic test_single;
        run_word(8'hA5, "single");
    endtask

    task automatic test_msb_first;
        run_word(8'h81, "msb");
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [3];
        logic [7:0] w;
        logic       exp_rdy;
        int         k;
        int         b;
        words[0] = 8'hFF; words[1] = 8'h00; words[2] = 8'h0F;
        k = 0;
        for (int c = 0; c < 26; c++) begin
            step();
            in_valid = (k < 3);
            in_data  = (k < 3) ? words[k] : 8'h00;
            #1;
            exp_rdy = !((c >= 2 && c <= 8) || (c >= 10 && c <= 16));
            checks++; if (l_in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp %b", c, l_in_ready, exp_rdy); end
            if (c >= 1 && c <= 24) begin
                w = words[(c - 1) / 8];
                b = (c - 1) % 8;
                checks++; if (l_bit_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", c, l_bit_valid); end
                checks++; if (l_bit_out !== w[b]) begin errors++; $display("FAIL b2b_bit[%0d] got %b exp %b", c, l_bit_out, w[b]); end
                checks++; if (l_bit_last !== (b == 7)) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", c, l_bit_last, (b == 7)); end
            end else if (c == 25) begin
                checks++; if (l_bit_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b exp 0", l_bit_valid); end
            end
            if (in_valid && l_in_ready) k++;
        end
        in_valid = 1'b0;
        checks++; if (k !== 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", k); end
    endtask

    task automatic test_backpressure;
        logic [7:0] w;
        int         eidx;
        int         hs;
        int         c;
        w = 8'h3C;
        step(); in_valid = 1'b1; in_data = w; bit_ready = 1'b1; #1;
        eidx = 0; hs = 0; c = 0;
        while (eidx < 8 && c < 40) begin
            step(); in_valid = 1'b0;
            bit_ready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            checks++; if (l_bit_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", c, l_bit_valid); end
            checks++; if (l_sel !== 3'(eidx)) begin errors++; $display("FAIL bp_sel[%0d] got %0d exp %0d", c, l_sel, eidx); end
            checks++; if (l_bit_out !== w[eidx]) begin errors++; $display("FAIL bp_bit[%0d] got %b exp %b", c, l_bit_out, w[eidx]); end
            if (bit_ready) begin eidx++; hs++; end
            c++;
        end
        step(); bit_ready = 1'b1; #1;
        checks++; if (hs !== 8) begin errors++; $display("FAIL bp_handshakes got %0d exp 8", hs); end
        checks++; if (l_bit_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b exp 0", l_bit_valid); end
    endtask

    task automatic test_reset_mid_word;
        step(); in_valid = 1'b1; in_data = 8'hAA; #1;
        step(); in_valid = 1'b1; in_data = 8'h55; #1;
        checks++; if (l_in_ready !== 1'b1) begin errors++; $display("FAIL mid_pre_ready got %b exp 1", l_in_ready); end
        step(); in_valid = 1'b0; #1;
        checks++; if ({l_in_ready, l_busy} !== 2'b01) begin errors++; $display("FAIL mid_full got %b exp 01", {l_in_ready, l_busy}); end
        step(); #1;
        step(); rst_n = 1'b0; #1;
        checks++; if (l_sel !== 3'd3) begin errors++; $display("FAIL mid_sel got %0d exp 3", l_sel); end
        step(); #1;
        checks++; if (l_bit_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", l_bit_valid); end
        checks++; if (l_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", l_busy); end
        checks++; if (l_in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", l_in_ready); end
        checks++; if (l_word !== 8'h00) begin errors++; $display("FAIL mid_rst_word got %h exp 00", l_word); end
        step(); rst_n = 1'b1; #1;
        checks++; if (l_in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready got %b exp 1", l_in_ready); end
        for (int i = 0; i < 10; i++) begin
            step(); #1;
            checks++; if (l_bit_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_valid[%0d] got %b exp 0", i, l_bit_valid); end
        end
        run_word(8'h01, "post_rst");
    endtask

    task automatic test_reset_hold_valid;
        step(); rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hC3; #1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            checks++; if (l_in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b exp 0", i, l_in_ready); end
            checks++; if (l_bit_valid !== 1'b0) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 0", i, l_bit_valid); end
        end
        step(); rst_n = 1'b1; #1;
        checks++; if (l_in_ready !== 1'b1) begin errors++; $display("FAIL hold_rel_ready got %b exp 1", l_in_ready); end
        step(); in_valid = 1'b0; #1;
        checks++; if ({l_bit_valid, l_bit_first, l_bit_out} !== 3'b111) begin errors++; $display("FAIL hold_first_bit got %b exp 111", {l_bit_valid, l_bit_first, l_bit_out}); end
        checks++; if (l_word !== 8'hC3) begin errors++; $display("FAIL hold_word got %h exp c3", l_word); end
        for (int i = 0; i < 8; i++) step();
        #1;
        checks++; if (l_busy !== 1'b0) begin errors++; $display("FAIL hold_end_busy got %b exp 0", l_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_msb_first();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_reset_hold_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
